// File: rtl/trdb_reg_apb.sv
// Trace encoder APB control/status register bank with trace-enable FSM and encoder clock gate.
// Optional build macro TRDB_REG_LOCK_EN adds a sticky CTRL[31] lock bit.
package trdb_reg_apb_pkg;
  typedef enum logic [2:0] {
    DELTA_ADDRESS      = 3'd0,
    FULL_ADDRESS       = 3'd1,
    IMPLICIT_EXCEPTION = 3'd2,
    SEQUENTIAL_JUMP    = 3'd3,
    IMPLICIT_RETURN    = 3'd4,
    BRANCH_PREDICTION  = 3'd5,
    JUMP_TARGET_CACHE  = 3'd6
  } ioptions_e;

  typedef enum logic [1:0] {
    TRC_OFF     = 2'd0,
    TRC_ARMED   = 2'd1,
    TRC_TRACING = 2'd2,
    TRC_DRAIN   = 2'd3
  } trace_state_e;
endpackage

// Latch-based clock gate: enable is captured while the clock is low so clk_o never glitches.
module trdb_clock_gating (
  input  logic clk_i,
  input  logic en_i,
  output logic clk_o
);
  logic en_latch;

  always_latch begin
    if (!clk_i) en_latch <= en_i;
  end

  assign clk_o = clk_i & en_latch;
endmodule

module trdb_reg_apb
  import trdb_reg_apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 12,
  parameter int unsigned DRAIN_CYCLES  = 4,
  parameter int unsigned EVT_CNT_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic [31:0]           pwdata_i,
  output logic [31:0]           prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  input  logic                  trace_req_on_i,
  input  logic                  trace_req_off_i,
  output logic                  trace_enable_o,
  output logic                  drain_o,
  output logic                  trace_activated_o,
  output logic                  nocontext_o,
  output logic                  notime_o,
  output logic                  delta_address_o,
  output logic                  encoder_mode_o,
  output ioptions_e             configuration_o,
  output logic                  clk_gated_o
);
  localparam logic [7:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? 8'(DRAIN_CYCLES - 1) : 8'd0;
  localparam logic [EVT_CNT_WIDTH-1:0] EVT_MAX = '1;

  trace_state_e             state_reg, state_next;
  logic [7:0]               drain_cnt_reg, drain_cnt_next;
  logic                     pending_reg, pending_next;
  logic [EVT_CNT_WIDTH-1:0] evt_cnt_reg;
  logic                     evt_inc;
  logic                     activated_reg, nocontext_reg, notime_reg, delta_reg, lock_reg;
  logic [2:0]               config_reg;

  logic       apb_access, apb_write, ctrl_wr, clr_wr, cfg_busy, cfg_diff, ctrl_err;
  logic       req_on, req_off, pend_eff;
  logic [1:0] reg_sel;
  logic [5:0] cfg_cur;
  logic [15:0] evt_ext;
  logic [31:0] ctrl_rdata, status_rdata;
  logic       unused_bits;

  assign apb_access = psel_i & penable_i;
  assign apb_write  = apb_access & pwrite_i;
  assign reg_sel    = paddr_i[3:2];
  assign ctrl_wr    = apb_write && (reg_sel == 2'd0);
  assign clr_wr     = apb_write && (reg_sel == 2'd2);
  assign unused_bits = ^{paddr_i[ADDR_WIDTH-1:4], paddr_i[1:0], pwdata_i[31:9]};

  // Encoder settings are frozen while the encoder is live (TRACING or DRAIN).
  assign cfg_busy = (state_reg == TRC_TRACING) || (state_reg == TRC_DRAIN);
  assign cfg_cur  = {config_reg, delta_reg, notime_reg, nocontext_reg};
  assign cfg_diff = (pwdata_i[8:3] != cfg_cur);
  assign ctrl_err = ctrl_wr & ((cfg_busy & cfg_diff) |
                               (lock_reg & (cfg_diff | (pwdata_i[0] != activated_reg))));

  assign req_on  = trace_req_on_i  | (ctrl_wr & pwdata_i[1]);
  assign req_off = trace_req_off_i | (ctrl_wr & pwdata_i[2]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      activated_reg <= 1'b0;
      nocontext_reg <= 1'b1;
      notime_reg    <= 1'b1;
      delta_reg     <= 1'b1;
      config_reg    <= DELTA_ADDRESS;
    end else if (ctrl_wr && !lock_reg) begin
      activated_reg <= pwdata_i[0];
      if (!cfg_busy) begin
        nocontext_reg <= pwdata_i[3];
        notime_reg    <= pwdata_i[4];
        delta_reg     <= pwdata_i[5];
        config_reg    <= pwdata_i[8:6];
      end
    end
  end

`ifdef TRDB_REG_LOCK_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lock_reg <= 1'b0;
    else if (ctrl_wr && !cfg_busy && pwdata_i[31]) lock_reg <= 1'b1;
  end
`else
  assign lock_reg = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    drain_cnt_next = drain_cnt_reg;
    pending_next   = pending_reg;
    evt_inc        = 1'b0;
    pend_eff       = !req_off && (req_on || pending_reg);
    case (state_reg)
      TRC_OFF: begin
        if (activated_reg) state_next = TRC_ARMED;
      end
      TRC_ARMED: begin
        if (!activated_reg) state_next = TRC_OFF;
        else if (req_on && !req_off) begin
          state_next = TRC_TRACING;
          evt_inc    = 1'b1;
        end
      end
      TRC_TRACING: begin
        if (req_off || !activated_reg) begin
          if (DRAIN_CYCLES == 0) begin
            state_next = activated_reg ? TRC_ARMED : TRC_OFF;
          end else begin
            state_next     = TRC_DRAIN;
            drain_cnt_next = DRAIN_LOAD;
          end
        end
      end
      TRC_DRAIN: begin
        if (drain_cnt_reg == 8'd0) begin
          pending_next = 1'b0;
          if (!activated_reg) state_next = TRC_OFF;
          else if (pend_eff) begin
            state_next = TRC_TRACING;
            evt_inc    = 1'b1;
          end else state_next = TRC_ARMED;
        end else begin
          drain_cnt_next = drain_cnt_reg - 8'd1;
          pending_next   = pend_eff;
        end
      end
      default: state_next = TRC_OFF;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= TRC_OFF;
      drain_cnt_reg <= 8'd0;
      pending_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
      pending_reg   <= pending_next;
    end
  end

  // A clear on the same edge as a trace start wins over the increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) evt_cnt_reg <= '0;
    else if (clr_wr) evt_cnt_reg <= '0;
    else if (evt_inc && (evt_cnt_reg != EVT_MAX)) evt_cnt_reg <= evt_cnt_reg + 1'b1;
  end

  assign evt_ext      = 16'(evt_cnt_reg);
  assign ctrl_rdata   = {lock_reg, 22'd0, config_reg, delta_reg, notime_reg, nocontext_reg,
                         2'b00, activated_reg};
  assign status_rdata = {evt_ext, 13'd0, pending_reg, state_reg};

  always_comb begin
    prdata_o = 32'd0;
    if (apb_access) begin
      case (reg_sel)
        2'd0:    prdata_o = ctrl_rdata;
        2'd1:    prdata_o = status_rdata;
        default: prdata_o = 32'd0;
      endcase
    end
  end

  assign pslverr_o = apb_access & ((reg_sel == 2'd3) | (pwrite_i & (reg_sel == 2'd1)) | ctrl_err);
  assign pready_o  = 1'b1;

  assign trace_enable_o    = (state_reg == TRC_TRACING);
  assign drain_o           = (state_reg == TRC_DRAIN);
  assign trace_activated_o = activated_reg;
  assign nocontext_o       = nocontext_reg;
  assign notime_o          = notime_reg;
  assign delta_address_o   = delta_reg;
  assign encoder_mode_o    = 1'b0;
  assign configuration_o   = ioptions_e'(config_reg);

  trdb_clock_gating i_clk_gate (
    .clk_i (clk_i),
    .en_i  (activated_reg | (state_reg != TRC_OFF)),
    .clk_o (clk_gated_o)
  );
endmodule
